// File: rtl/qracc_sram_ctrl.sv
// ----------------------------------------------------------------------------
// qracc_sram_ctrl
//
// Responder end of the QRAcc SRAM request interface. Takes one read or write
// request at a time from the digital master on a valid/ready handshake and
// sequences the analog SRAM control pins of the array macro:
//   write : WR_WL (wordline + write enable + column select + write data)
//   read  : RD_PCH (precharge) -> RD_WL (wordline) -> RD_SENSE (wordline +
//           sense-amp enable + column select) -> RD_DONE (rd_valid pulse)
// The sense-amp outputs are captured into rd_data_o at the final edge of the
// sense phase and held there until the next read capture.
//
// Every output is driven straight from a flop. Each output flop is loaded
// from a decode of the *next* state, so a pin changes on the same edge on
// which its state is entered.
//
// Ports:
//   clk         in   sole clock, rising edge
//   nrst        in   asynchronous active-low reset
//   rq_wr_i     in   1 = write request, 0 = read request
//   rq_valid_i  in   request valid
//   rq_ready_o  out  request accepted on rq_valid_i & rq_ready_o at a rising edge
//   rd_valid_o  out  one-cycle pulse, rd_data_o valid
//   rd_data_o   out  [numCols]   read data
//   wr_data_i   in   [numCols]   write data
//   addr_i      in   [log2 rows] row address
//   wl_o        out  [numRows]   one-hot wordline to analog
//   pch_o       out  bitline precharge, active high
//   wr_data_o   out  [numCols]   write data to analog
//   write_o     out  write enable to analog
//   csel_o      out  [numCols]   column select, all ones when active
//   saen_o      out  sense-amp enable
//   sa_out_i    in   [numCols]   sense-amp outputs from analog
// ----------------------------------------------------------------------------
module qracc_sram_ctrl #(
  parameter int numRows   = 128,
  parameter int numCols   = 32,
  parameter int pchCycles = 1,
  parameter int wlCycles  = 2,
  parameter int saCycles  = 1
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       rq_wr_i,
  input  logic                       rq_valid_i,
  output logic                       rq_ready_o,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  input  logic [numCols-1:0]         wr_data_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  output logic [numRows-1:0]         wl_o,
  output logic                       pch_o,
  output logic [numCols-1:0]         wr_data_o,
  output logic                       write_o,
  output logic [numCols-1:0]         csel_o,
  output logic                       saen_o,
  input  logic [numCols-1:0]         sa_out_i
);

  localparam int ADDR_W = $clog2(numRows);

  // Longest dwell of any phase; the counter only has to hold (dwell - 1).
  localparam int MAX_CYC = (pchCycles > wlCycles)
                         ? ((pchCycles > saCycles) ? pchCycles : saCycles)
                         : ((wlCycles  > saCycles) ? wlCycles  : saCycles);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] PCH_LOAD = CNT_W'(pchCycles - 1);
  localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(wlCycles - 1);
  localparam logic [CNT_W-1:0] SA_LOAD  = CNT_W'(saCycles - 1);

  localparam logic [numRows-1:0] WL_ONE = numRows'(1);

  typedef enum logic [2:0] {
    IDLE,
    WR_WL,
    RD_PCH,
    RD_WL,
    RD_SENSE,
    RD_DONE
  } state_e;

  // Control state
  state_e              state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [numCols-1:0]  wdata_q,   wdata_d;

  // Output flops
  logic                ready_q,   ready_d;
  logic                rdvalid_q, rdvalid_d;
  logic [numCols-1:0]  rddata_q,  rddata_d;
  logic [numRows-1:0]  wl_q,      wl_d;
  logic                pch_q,     pch_d;
  logic [numCols-1:0]  wrdata_q,  wrdata_d;
  logic                write_q,   write_d;
  logic [numCols-1:0]  csel_q,    csel_d;
  logic                saen_q,    saen_d;

  logic                handshake;
  logic                cnt_done;
  logic [numRows-1:0]  wl_sel;

  // ready_q is low on the first edge out of reset even though the FSM is
  // already in IDLE, so a request is never taken before ready is visible.
  assign handshake = (state_q == IDLE) && ready_q && rq_valid_i;
  assign cnt_done  = (cnt_q == '0);

  // Next-state logic. The dwell counter is loaded with (cycles - 1) on entry
  // to each timed phase and the phase ends when it reaches zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rddata_d = rddata_q;

    case (state_q)
      IDLE: begin
        if (handshake) begin
          addr_d  = addr_i;
          wdata_d = wr_data_i;
          if (rq_wr_i) begin
            state_d = WR_WL;
            cnt_d   = WL_LOAD;
          end else begin
            state_d = RD_PCH;
            cnt_d   = PCH_LOAD;
          end
        end
      end

      WR_WL: begin
        if (cnt_done) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RD_PCH: begin
        if (cnt_done) begin
          state_d = RD_WL;
          cnt_d   = WL_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RD_WL: begin
        if (cnt_done) begin
          state_d = RD_SENSE;
          cnt_d   = SA_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RD_SENSE: begin
        // Capture on the edge that closes the last sense cycle.
        if (cnt_done) begin
          state_d  = RD_DONE;
          rddata_d = sa_out_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RD_DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state, so each pin is registered and lines
  // up with the state it belongs to. addr_d already holds the fresh address
  // on the accepting edge.
  always_comb begin
    wl_sel    = WL_ONE << addr_d;
    ready_d   = 1'b0;
    rdvalid_d = 1'b0;
    wl_d      = '0;
    pch_d     = 1'b0;
    wrdata_d  = '0;
    write_d   = 1'b0;
    csel_d    = '0;
    saen_d    = 1'b0;

    case (state_d)
      IDLE: begin
        ready_d = 1'b1;
      end

      WR_WL: begin
        wl_d     = wl_sel;
        write_d  = 1'b1;
        wrdata_d = wdata_d;
        csel_d   = '1;
      end

      RD_PCH: begin
        pch_d = 1'b1;
      end

      RD_WL: begin
        wl_d = wl_sel;
      end

      RD_SENSE: begin
        wl_d   = wl_sel;
        saen_d = 1'b1;
        csel_d = '1;
      end

      RD_DONE: begin
        rdvalid_d = 1'b1;
      end

      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // State, counter and request capture registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Output registers; reset clears every pin at once, aborting any access.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ready_q   <= 1'b0;
      rdvalid_q <= 1'b0;
      rddata_q  <= '0;
      wl_q      <= '0;
      pch_q     <= 1'b0;
      wrdata_q  <= '0;
      write_q   <= 1'b0;
      csel_q    <= '0;
      saen_q    <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      rdvalid_q <= rdvalid_d;
      rddata_q  <= rddata_d;
      wl_q      <= wl_d;
      pch_q     <= pch_d;
      wrdata_q  <= wrdata_d;
      write_q   <= write_d;
      csel_q    <= csel_d;
      saen_q    <= saen_d;
    end
  end

  assign rq_ready_o = ready_q;
  assign rd_valid_o = rdvalid_q;
  assign rd_data_o  = rddata_q;
  assign wl_o       = wl_q;
  assign pch_o      = pch_q;
  assign wr_data_o  = wrdata_q;
  assign write_o    = write_q;
  assign csel_o     = csel_q;
  assign saen_o     = saen_q;

endmodule

// File: doc/qracc_sram_ctrl.md
Name: qracc_sram_ctrl

Overview:
- Digital responder (slave end) of the QRAcc SRAM request interface `sram_itf`.
- Accepts read/write requests from the digital master on a valid/ready handshake.
- Sequences the analog SRAM control pins of the array: WL, PCH, WR_DATA, WRITE, CSEL, SAEN.
- Captures SA_OUT and returns read data with a one-cycle rd_valid pulse. Sits between the qracc controller and the analog macro's SRAM port.

Parameters:
- numRows, 128, array rows; power of two; addr width = $clog2(numRows).
- numCols, 32, array columns / data word width.
- pchCycles, 1, cycles PCH is held before a read; >=1.
- wlCycles, 2, cycles the wordline is held (read and write); >=1.
- saCycles, 1, cycles SAEN is held; >=1.

Ports:
- clk  input  1  sole clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- rq_wr_i  input  1  1 = write request, 0 = read request.
- rq_valid_i  input  1  request valid.
- rq_ready_o  output  1  request taken when rq_valid_i & rq_ready_o at a rising edge.
- rd_valid_o  output  1  one-cycle pulse; rd_data_o valid.
- rd_data_o  output  numCols  read data.
- wr_data_i  input  numCols  write data.
- addr_i  input  $clog2(numRows)  row address.
- wl_o  output  numRows  one-hot wordline to analog.
- pch_o  output  1  bitline precharge, active high.
- wr_data_o  output  numCols  write data to analog.
- write_o  output  1  write enable to analog.
- csel_o  output  numCols  column select; all ones when active.
- saen_o  output  1  sense-amp enable.
- sa_out_i  input  numCols  sense-amp outputs from analog.

Behaviour:
- Reset (async, nrst low):
  - All outputs 0: rq_ready_o, rd_valid_o, rd_data_o, wl_o, pch_o, wr_data_o, write_o, csel_o, saen_o.
  - FSM goes to IDLE; counters cleared.
  - Reset asserted mid-operation aborts the operation immediately. No rd_valid is issued for an aborted read.
- Register rules:
  - All analog-facing outputs come directly from flops; no combinational path from inputs.
  - rq_ready_o is registered: 1 only while in IDLE, rising on the first clk edge after nrst deasserts.
- States: IDLE, WR_WL, RD_PCH, RD_WL, RD_SENSE, RD_DONE.
- IDLE:
  - rq_ready_o=1.
  - On handshake: latch addr_i, rq_wr_i, wr_data_i; rq_ready_o drops to 0 the next cycle.
  - Next state is WR_WL if write, else RD_PCH.
  - rq_valid_i while not ready is ignored; master must hold the request.
- WR_WL, wlCycles cycles:
  - wl_o[addr]=1, write_o=1, wr_data_o=latched data, csel_o all ones.
  - Then IDLE, with rq_ready_o=1 in the cycle after the last WR_WL cycle.
  - On exit, wr_data_o returns to 0.
- RD_PCH, pchCycles cycles: pch_o=1, wl_o=0.
- RD_WL, wlCycles cycles: wl_o[addr]=1, pch_o=0.
- RD_SENSE, saCycles cycles:
  - wl_o[addr] stays 1; saen_o=1; csel_o all ones.
  - sa_out_i is sampled into rd_data_o at the last rising edge of the final sense cycle.
- RD_DONE, 1 cycle: rd_valid_o=1 and all analog outputs 0. Then IDLE with rq_ready_o=1.
- rd_data_o holds its value until the next read capture. Writes do not change it.
- Read latency, counted from the accepting edge: rd_valid_o is high in cycle pchCycles+wlCycles+saCycles+1. Default is 5.
- Read occupancy: next request is accepted no earlier than pchCycles+wlCycles+saCycles+2 edges after the previous one (default 6).
- Write occupancy: next request is accepted no earlier than wlCycles+1 edges after the previous one (default 3).
- Invariants:
  - wl_o is zero or one-hot.
  - pch_o and any wl_o bit are never high in the same cycle.
  - write_o and saen_o are never high together.
- Dwell counter: width sufficient for max(pchCycles, wlCycles, saCycles); reloads on each state entry.
- Back-to-back: a request presented in the same cycle rq_ready_o rises is accepted at that edge.

Test Plan:
1. Reset then idle: nrst low for 3 cycles, then release -> all outputs 0 during reset; rq_ready_o=1 one edge after release; no activity with rq_valid_i=0.
2. Write: rq_wr_i=1, addr_i=5, wr_data_i=32'hA5A5_F00F -> wl_o[5]=1, write_o=1, csel_o=32'hFFFF_FFFF, wr_data_o=32'hA5A5_F00F for exactly 2 cycles; rq_ready_o back 3 edges after accept.
3. Read, defaults: addr_i=127, sa_out_i=32'h1234_5678 during sense -> pch_o high 1 cycle, wl_o[127] high 3 cycles (2 WL + 1 sense), saen_o high 1 cycle, then rd_valid_o pulse in cycle 5 with rd_data_o=32'h1234_5678; pch_o/wl_o never overlap.
4. Back-to-back write then read at addr 0: rq_valid_i held continuously -> read accepted the edge rq_ready_o rises; rd_data_o after the write still holds the previous read value until the new capture.
5. Parameter sweep pchCycles=3, wlCycles=4, saCycles=2 -> rd_valid_o in cycle 10 after accept; next accept at edge 11.
6. Reset mid-read (nrst low during RD_WL) -> wl_o, pch_o, saen_o cleared asynchronously; no rd_valid_o pulse; a clean read succeeds after reset release.
